// File: rtl/sim_ram_pkg.sv
// sim_ram_pkg: shared types, byte-mask helper and the backing RAM model for the sim memory ports
package sim_ram_pkg;
  localparam int BEAT_W = 64;
  localparam int MAX_DATA_W = 512;
  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  is_write;
    logic                  err;
  } sim_ram_resp_t;
  // 64-bit beat store standing in for the C++ RAM model, plus call counters for observability
  logic [BEAT_W-1:0] ram_mem [longint unsigned];
  int unsigned ram_rd_calls;
  int unsigned ram_wr_calls;
  function automatic logic [BEAT_W-1:0] expand_bytemask(input logic [7:0] m);
    logic [BEAT_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction
  function automatic logic [BEAT_W-1:0] ram_read_helper(input bit en, input longint unsigned addr);
    if (!en) return '0;
    ram_rd_calls++;
    return ram_mem.exists(addr) ? ram_mem[addr] : '0;
  endfunction
  function automatic void ram_write_helper(input longint unsigned addr, input logic [BEAT_W-1:0] data,
                                           input logic [BEAT_W-1:0] mask, input bit en);
    logic [BEAT_W-1:0] old;
    if (!en) return;
    ram_wr_calls++;
    old = ram_mem.exists(addr) ? ram_mem[addr] : '0;
    ram_mem[addr] = (old & ~mask) | (data & mask);
  endfunction
endpackage

// File: rtl/sim_ram_resp_fifo.sv
// sim_ram_resp_fifo: small typed response FIFO with wrapping pointers and occupancy count
module sim_ram_resp_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers and occupancy, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop) rp <= inc(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/sim_ram_port.sv
// sim_ram_port: valid/ready memory port over the beat RAM model with fixed latency and credit-bounded outstanding requests
module sim_ram_port
  import sim_ram_pkg::*;
#(
  parameter int IDX_W = 52,
  parameter int DATA_W = 128,
  parameter int LATENCY = 2,
  parameter int DEPTH = 4,
  parameter longint unsigned MEM_WORDS = 64'd1 << 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [IDX_W-1:0]    req_idx,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_is_write,
  output logic                resp_err
);
  localparam int BEATS = DATA_W / BEAT_W;
  localparam int CW = $clog2(DEPTH + 1);
  if (DATA_W % BEAT_W != 0 || DATA_W > MAX_DATA_W) begin : g_chk_width
    $fatal(1, "sim_ram_port: DATA_W=%0d must be a multiple of 64 and at most %0d", DATA_W, MAX_DATA_W);
  end
  if (LATENCY < 1 || DEPTH < LATENCY) begin : g_chk_lat
    $fatal(1, "sim_ram_port: need LATENCY>=1 and DEPTH>=LATENCY (LATENCY=%0d DEPTH=%0d)", LATENCY, DEPTH);
  end
  logic accept, pop, push, empty, full, rdy_q, unused_bits;
  logic [LATENCY-1:0] pv;
  sim_ram_resp_t pd [LATENCY];
  sim_ram_resp_t head;
  logic [CW-1:0] out_cnt, cnt_nx;
  assign accept = req_valid && req_ready;
  assign pop = resp_valid && resp_ready;
  assign push = pv[LATENCY-1];
  assign req_ready = rdy_q;
  assign resp_valid = !empty;
  assign resp_rdata = resp_valid ? head.rdata[DATA_W-1:0] : '0;
  assign resp_is_write = resp_valid && head.is_write;
  assign resp_err = resp_valid && head.err;
  assign unused_bits = ^head.rdata;
  // performs the whole access at accept time; out-of-range indices never touch the RAM
  function automatic sim_ram_resp_t do_access(input logic wen, input logic [IDX_W-1:0] idx,
                                              input logic [DATA_W-1:0] wd, input logic [DATA_W/8-1:0] wm);
    sim_ram_resp_t r;
    longint unsigned a;
    r = '0;
    r.is_write = wen;
    if (64'(idx) >= MEM_WORDS) r.err = 1'b1;
    else
      for (int k = 0; k < BEATS; k++) begin
        a = 64'(idx) * 64'(BEATS) + 64'(k);
        if (!wen) r.rdata[k*BEAT_W +: BEAT_W] = ram_read_helper(1'b1, a);
        else if (wm[k*8 +: 8] != '0)
          ram_write_helper(a, wd[k*BEAT_W +: BEAT_W], expand_bytemask(wm[k*8 +: 8]), 1'b1);
      end
    return r;
  endfunction
  // latency pipe payload; only the accept cycle calls into the RAM
  always_ff @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) pd[i] <= pd[i-1];
    if (accept) pd[0] <= do_access(req_wen, req_idx, req_wdata, req_wmask);
  end
  // latency pipe valid bits, flushed by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pv <= '0;
    else pv <= (pv << 1) | LATENCY'(accept);
  sim_ram_resp_fifo #(.T(sim_ram_resp_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(pd[LATENCY-1]),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // outstanding count covers both pipe and FIFO, so neither can overflow
  always_comb cnt_nx = out_cnt + CW'(accept) - CW'(pop);
  // ready is registered from the next count so resp_ready never reaches req_ready combinationally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_cnt <= '0;
      rdy_q <= 1'b0;
    end else begin
      out_cnt <= cnt_nx;
      rdy_q <= cnt_nx < CW'(DEPTH);
    end
  a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid && !resp_ready |=> resp_valid && $stable(resp_rdata) && $stable(resp_is_write) && $stable(resp_err));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) out_cnt <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
endmodule

// File: tb/tb_sim_ram_port.sv
// tb_sim_ram_port: directed stimulus against a word-level memory/queue model plus literal pins
module tb_sim_ram_port;
  import sim_ram_pkg::*;
  localparam int L = 2;
  localparam int D = 4;
  localparam longint unsigned MW = 64'd1 << 20;
  localparam logic [127:0] DA = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] DC = 128'hCAFEF00D_00000000_00000000_12345678;
  localparam logic [127:0] ONES = {128{1'b1}};
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
  logic [51:0] req_idx = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0] req_wmask = '0;
  logic req_ready, resp_valid, resp_is_write, resp_err;
  logic [127:0] resp_rdata;
  typedef struct {logic [127:0] dat; logic wr; logic er; int cyc;} rec_t;
  rec_t q[$];
  rec_t got[$];
  int acc[$];
  logic [127:0] mem [longint unsigned];
  int cyc = 0, cnt = 0, checks = 0, failures = 0;
  logic rdy_exp = 1'b0, acc_n = 1'b0, pop_n = 1'b0;

  sim_ram_port #(.IDX_W(52), .DATA_W(128), .LATENCY(L), .DEPTH(D), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_idx(req_idx), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_is_write(resp_is_write), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic rec_t access(input logic w, input logic [51:0] i, input logic [127:0] wd,
                                  input logic [15:0] wm, input int due);
    rec_t r;
    logic [127:0] cur;
    r = '{dat: '0, wr: w, er: 1'b0, cyc: due};
    if (64'(i) >= MW) begin
      r.er = 1'b1;
      return r;
    end
    cur = mem.exists(64'(i)) ? mem[64'(i)] : '0;
    if (w) begin
      for (int b = 0; b < 16; b++) if (wm[b]) cur[8*b +: 8] = wd[8*b +: 8];
      mem[64'(i)] = cur;
    end else r.dat = cur;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cnt = 0;
      rdy_exp = 1'b0;
    end else begin
      cyc++;
      if (pop_n && q.size() > 0) void'(q.pop_front());
      if (acc_n) begin
        q.push_back(access(req_wen, req_idx, req_wdata, req_wmask, cyc + L));
        acc.push_back(cyc);
      end
      cnt = cnt + int'(acc_n) - int'(pop_n);
      rdy_exp = cnt < D;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", 128'(resp_valid), 128'(q.size() > 0 && q[0].cyc <= cyc));
      if (resp_valid && q.size() > 0) begin
        chk("model_rdata", resp_rdata, q[0].dat);
        chk("model_flags", 128'({resp_is_write, resp_err}), 128'({q[0].wr, q[0].er}));
      end
      chk("model_ready", 128'(req_ready), 128'(rdy_exp));
      if (resp_valid && resp_ready) got.push_back('{resp_rdata, resp_is_write, resp_err, cyc});
    end
    acc_n = rst_n && req_valid && req_ready;
    pop_n = rst_n && resp_valid && resp_ready;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic w, input logic [51:0] i, input logic [127:0] d, input logic [15:0] m);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    req_valid = 1'b1; req_wen = w; req_idx = i; req_wdata = d; req_wmask = m;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    chk("send_accepted", 128'(ok), 128'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      step(1);
      n++;
    end
    step(1);
    chk("drain_empty", 128'(q.size()), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, a, k, n;
    int unsigned r0, w0;
    logic [51:0] ix [4];
    ix = '{52'd5, 52'd9, 52'd0, 52'd5};
    #1;
    chk("rst_ready", 128'(req_ready), 128'd0);
    chk("rst_valid", 128'(resp_valid), 128'd0);
    chk("rst_rdata", resp_rdata, 128'd0);
    chk("rst_flags", 128'({resp_is_write, resp_err}), 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("release_first_cycle_ready", 128'(req_ready), 128'd0);
    step(1);
    chk("release_ready", 128'(req_ready), 128'd1);
    // write then read back the same word
    b = got.size();
    a = acc.size();
    send(1'b1, 52'd5, DA, 16'hFFFF);
    send(1'b0, 52'd5, '0, '0);
    drain();
    chk("t2_wr_flag", 128'(got[b].wr), 128'd1);
    chk("t2_wr_rdata", got[b].dat, 128'd0);
    chk("t2_wr_latency", 128'(got[b].cyc - acc[a]), 128'd2);
    chk("t2_rd_rdata", got[b+1].dat, DA);
    chk("t2_rd_latency", 128'(got[b+1].cyc - acc[a]), 128'd3);
    // partial byte write, upper beat untouched
    b = got.size();
    send(1'b1, 52'd9, ONES, 16'hFFFF);
    w0 = ram_wr_calls;
    send(1'b1, 52'd9, 128'hAA, 16'h0001);
    chk("t3_wr_calls", 128'(ram_wr_calls - w0), 128'd1);
    send(1'b0, 52'd9, '0, '0);
    drain();
    chk("t3_rd_rdata", got[b+2].dat, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFAA);
    // backpressure fills all credits
    b = got.size();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_wen = 1'b0;
    k = 0;
    req_idx = ix[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready) k++;
      @(posedge clk);
      #1;
      req_idx = ix[k % 4];
    end
    req_valid = 1'b0;
    chk("t4_accepted", 128'(k), 128'd4);
    chk("t4_ready_full", 128'(req_ready), 128'd0);
    chk("t4_valid_held", 128'(resp_valid), 128'd1);
    chk("t4_head_held", resp_rdata, DA);
    resp_ready = 1'b1;
    chk("t4_ready_before_pop", 128'(req_ready), 128'd0);
    step(1);
    chk("t4_ready_after_pop", 128'(req_ready), 128'd1);
    drain();
    chk("t4_resp0", got[b].dat, DA);
    chk("t4_resp1", got[b+1].dat, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFAA);
    chk("t4_resp2", got[b+2].dat, 128'd0);
    chk("t4_resp3", got[b+3].dat, DA);
    // sustained streaming
    b = got.size();
    a = acc.size();
    req_valid = 1'b1;
    req_wen = 1'b0;
    req_idx = '0;
    k = 0;
    n = 0;
    while (k < 100 && n < 300) begin
      @(negedge clk);
      if (req_ready) k++;
      @(posedge clk);
      #1;
      n++;
      req_idx = 52'(k % 16);
    end
    req_valid = 1'b0;
    drain();
    chk("t5_count", 128'(got.size() - b), 128'd100);
    chk("t5_accept_span", 128'(acc[a+99] - acc[a]), 128'd99);
    chk("t5_resp_span", 128'(got[b+99].cyc - acc[a] + 1), 128'd102);
    // out-of-range index
    b = got.size();
    send(1'b1, 52'd0, DC, 16'hFFFF);
    r0 = ram_rd_calls;
    w0 = ram_wr_calls;
    send(1'b0, 52'(MW), '0, '0);
    send(1'b1, 52'(MW), DA, 16'hFFFF);
    chk("t6_no_ram_calls", 128'((ram_rd_calls - r0) + (ram_wr_calls - w0)), 128'd0);
    send(1'b0, 52'd0, '0, '0);
    chk("t6_rd_calls", 128'(ram_rd_calls - r0), 128'd2);
    drain();
    chk("t6_err_rd", 128'({got[b+1].er, got[b+1].wr}), 128'b10);
    chk("t6_err_rdata", got[b+1].dat, 128'd0);
    chk("t6_err_wr", 128'({got[b+2].er, got[b+2].wr}), 128'b11);
    chk("t6_ok_rd", got[b+3].dat, DC);
    chk("t6_ok_err", 128'(got[b+3].er), 128'd0);
    // reset with requests outstanding
    resp_ready = 1'b0;
    send(1'b0, 52'd5, '0, '0);
    send(1'b0, 52'd9, '0, '0);
    send(1'b0, 52'd0, '0, '0);
    chk("t1_valid_before", 128'(resp_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_valid_in_reset", 128'(resp_valid), 128'd0);
    chk("t1_ready_in_reset", 128'(req_ready), 128'd0);
    b = got.size();
    step(2);
    rst_n = 1'b1;
    chk("t1_ready_release_cycle", 128'(req_ready), 128'd0);
    resp_ready = 1'b1;
    step(1);
    chk("t1_ready_after", 128'(req_ready), 128'd1);
    chk("t1_out_cnt", 128'(dut.out_cnt), 128'd0);
    step(6);
    chk("t1_no_stale", 128'(got.size() - b), 128'd0);
    chk("t1_valid_idle", 128'(resp_valid), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
